// File: rtl/load_pkg.sv
// Shared encodings and helpers for the load/store byte-lane path.
package load_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT0 = 2'd1,
    WAIT1 = 2'd2,
    RESP  = 2'd3
  } state_e;

  function automatic logic [3:0] nbytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/lsu_byte_extract.sv
// Selects nb bytes starting at byte offset off from a two-word window and
// zero- or sign-extends them to a full word.
module lsu_byte_extract #(
  parameter  int DATA_W = 32,
  localparam int OFFW   = $clog2(DATA_W / 8)
) (
  input  logic [2*DATA_W-1:0] words,
  input  logic [OFFW-1:0]     off,
  input  logic [3:0]          nb,
  input  logic                isUnsigned,
  output logic [DATA_W-1:0]   extended
);

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  logic [DATA_W-1:0] low;
  logic [DATA_W-1:0] keep;
  logic [DATA_W-1:0] fill;
  logic              signBit;
  int unsigned       nbBits;

  always_comb begin
    low    = DATA_W'(words >> {off, 3'b000});
    nbBits = 32'(nb) << 3;
    keep   = '1;
    if (nbBits < DATA_W) keep = (ONE << nbBits) - ONE;
    // Full-width accesses keep every bit, so the sign bit is never used there.
    signBit  = |(low & (ONE << (nbBits - 1)));
    fill     = (signBit && !isUnsigned) ? '1 : '0;
    extended = (low & keep) | (fill & ~keep);
  end

endmodule

// File: rtl/load_align_unit.sv
// Load-data path: issues one or two word-aligned reads per request and
// returns the selected bytes extended to a full word.
module load_align_unit
  import load_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int ALLOW_MISALIGN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_exc
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFFW  = $clog2(BYTES);

  state_e            state;
  logic [OFFW-1:0]   offQ;
  logic [3:0]        nbQ;
  logic              unsQ;
  logic              spanQ;
  logic [ADDR_W-1:0] wordAddrQ;
  logic [DATA_W-1:0] w0Q;
  logic [DATA_W-1:0] rspDataQ;
  logic              rspExcQ;

  logic [OFFW-1:0]     reqOff;
  logic [3:0]          reqNb;
  logic [ADDR_W-1:0]   reqWordAddr;
  logic                reqSpan;
  logic                reqIllegal;
  logic                accept;
  logic [2*DATA_W-1:0] window;
  logic [DATA_W-1:0]   extended;

  always_comb begin
    reqOff      = req_addr[OFFW-1:0];
    reqNb       = nbytes(req_size);
    reqWordAddr = {req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
    reqSpan     = (int'(reqOff) + int'(reqNb)) > BYTES;
    reqIllegal  = (int'(reqNb) > BYTES) || (reqSpan && (ALLOW_MISALIGN == 0));
    accept      = (state == IDLE) && req_valid && !reset;
  end

  // Read strobes are combinational so the data lands in the very next state.
  always_comb begin
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    if (accept && !reqIllegal) begin
      mem_rd_en = 1'b1;
      mem_addr  = reqWordAddr;
    end else if ((state == WAIT0) && spanQ && !reset) begin
      mem_rd_en = 1'b1;
      mem_addr  = wordAddrQ + ADDR_W'(BYTES);
    end
  end

  always_comb begin
    window = {{DATA_W{1'b0}}, mem_rdata};
    if (state == WAIT1) window = {mem_rdata, w0Q};
  end

  lsu_byte_extract #(.DATA_W(DATA_W)) uExtract (
    .words      (window),
    .off        (offQ),
    .nb         (nbQ),
    .isUnsigned (unsQ),
    .extended   (extended)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      offQ      <= '0;
      nbQ       <= '0;
      unsQ      <= 1'b0;
      spanQ     <= 1'b0;
      wordAddrQ <= '0;
      w0Q       <= '0;
      rspDataQ  <= '0;
      rspExcQ   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            offQ      <= reqOff;
            nbQ       <= reqNb;
            unsQ      <= req_unsigned;
            spanQ     <= reqSpan;
            wordAddrQ <= reqWordAddr;
            if (reqIllegal) begin
              rspDataQ <= '0;
              rspExcQ  <= 1'b1;
              state    <= RESP;
            end else begin
              state <= WAIT0;
            end
          end
        end
        WAIT0: begin
          w0Q <= mem_rdata;
          if (spanQ) begin
            state <= WAIT1;
          end else begin
            rspDataQ <= extended;
            rspExcQ  <= 1'b0;
            state    <= RESP;
          end
        end
        WAIT1: begin
          rspDataQ <= extended;
          rspExcQ  <= 1'b0;
          state    <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_data  = rspDataQ;
  assign rsp_exc   = rspExcQ;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: one misalign-capable and one strict instance.
module tb_load_align_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqValid;
  logic        sel;
  logic [31:0] reqAddr;
  logic [1:0]  reqSize;
  logic        reqUnsigned;
  logic [31:0] memRdata;
  logic        rspReady;

  logic        reqReady0, reqReady1, memRdEn0, memRdEn1;
  logic [31:0] memAddr0, memAddr1, rspData0, rspData1;
  logic        rspValid0, rspValid1, rspExc0, rspExc1;

  logic        reqReady, memRdEn, rspValid, rspExc;
  logic [31:0] memAddr, rspData;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] readQ [$];

  int nChecks = 0;
  int nErrors = 0;
  int lat;

  always #5 clk = ~clk;

  load_align_unit #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGN(1)) dut0 (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (reqValid & ~sel),
    .req_ready    (reqReady0),
    .req_addr     (reqAddr),
    .req_size     (reqSize),
    .req_unsigned (reqUnsigned),
    .mem_rd_en    (memRdEn0),
    .mem_addr     (memAddr0),
    .mem_rdata    (memRdata),
    .rsp_valid    (rspValid0),
    .rsp_ready    (rspReady & ~sel),
    .rsp_data     (rspData0),
    .rsp_exc      (rspExc0)
  );

  load_align_unit #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGN(0)) dut1 (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (reqValid & sel),
    .req_ready    (reqReady1),
    .req_addr     (reqAddr),
    .req_size     (reqSize),
    .req_unsigned (reqUnsigned),
    .mem_rd_en    (memRdEn1),
    .mem_addr     (memAddr1),
    .mem_rdata    (memRdata),
    .rsp_valid    (rspValid1),
    .rsp_ready    (rspReady & sel),
    .rsp_data     (rspData1),
    .rsp_exc      (rspExc1)
  );

  assign reqReady = sel ? reqReady1 : reqReady0;
  assign memRdEn  = sel ? memRdEn1  : memRdEn0;
  assign memAddr  = sel ? memAddr1  : memAddr0;
  assign rspValid = sel ? rspValid1 : rspValid0;
  assign rspData  = sel ? rspData1  : rspData0;
  assign rspExc   = sel ? rspExc1   : rspExc0;

  function automatic logic [31:0] memRead(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // One-cycle read memory shared by both instances.
  always @(posedge clk) begin
    if (memRdEn0 | memRdEn1) begin
      memRdata <= memRead(memAddr);
      readQ.push_back(memAddr);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic runLoad(input logic [31:0] a, input logic [1:0] sz, input logic u,
                         output int latency);
    reqAddr     = a;
    reqSize     = sz;
    reqUnsigned = u;
    reqValid    = 1'b1;
    readQ.delete();
    #1;
    chk("req_ready at accept", 32'(reqReady), 32'd1);
    tick;
    reqValid = 1'b0;
    latency  = 1;
    while (!rspValid && latency < 8) begin
      tick;
      latency++;
    end
  endtask

  task automatic finishRsp;
    rspReady = 1'b1;
    tick;
    rspReady = 1'b0;
    chk("req_ready after handshake", 32'(reqReady), 32'd1);
    chk("rsp_valid after handshake", 32'(rspValid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; reqValid = 1'b0; sel = 1'b0; reqAddr = '0; reqSize = '0;
    reqUnsigned = 1'b0; rspReady = 1'b0; memRdata = '0;
    repeat (2) tick;
    reset = 1'b0;
    #1;
    chk("reset rsp_valid", 32'(rspValid), 32'd0);
    chk("reset rsp_exc", 32'(rspExc), 32'd0);
    chk("reset rsp_data", rspData, 32'h0);
    chk("reset mem_rd_en", 32'(memRdEn), 32'd0);
    chk("reset mem_addr", memAddr, 32'h0);
    chk("reset req_ready", 32'(reqReady), 32'd1);

    // lb, signed and unsigned
    mem[32'h1000] = 32'h80FF_1234;
    runLoad(32'h1003, 2'd0, 1'b0, lat);
    chk("lb signed latency", 32'(lat), 32'd2);
    chk("lb signed data", rspData, 32'hFFFF_FF80);
    chk("lb signed exc", 32'(rspExc), 32'd0);
    chk("lb reads", 32'(readQ.size()), 32'd1);
    chk("lb read addr", readQ[0], 32'h1000);
    finishRsp;
    runLoad(32'h1003, 2'd0, 1'b1, lat);
    chk("lb unsigned data", rspData, 32'h0000_0080);
    finishRsp;

    // lh aligned
    mem[32'h1000] = 32'h8001_5678;
    runLoad(32'h1002, 2'd1, 1'b0, lat);
    chk("lh latency", 32'(lat), 32'd2);
    chk("lh signed data", rspData, 32'hFFFF_8001);
    chk("lh single read", 32'(readQ.size()), 32'd1);
    finishRsp;
    runLoad(32'h1002, 2'd1, 1'b1, lat);
    chk("lh unsigned data", rspData, 32'h0000_8001);
    finishRsp;

    // lw spanning two words
    mem[32'h1000] = 32'h4433_2211;
    mem[32'h1004] = 32'h8877_6655;
    mem[32'h1008] = 32'h0000_00CC;
    runLoad(32'h1001, 2'd2, 1'b0, lat);
    chk("lw span latency", 32'(lat), 32'd3);
    chk("lw span data", rspData, 32'h5544_3322);
    chk("lw span reads", 32'(readQ.size()), 32'd2);
    chk("lw span read0", readQ[0], 32'h1000);
    chk("lw span read1", readQ[1], 32'h1004);
    finishRsp;
    runLoad(32'h1007, 2'd1, 1'b0, lat);
    chk("lh span latency", 32'(lat), 32'd3);
    chk("lh span data", rspData, 32'hFFFF_CC88);
    finishRsp;

    // oversize on the misalign-capable instance
    runLoad(32'h1000, 2'd3, 1'b0, lat);
    chk("ld oversize latency", 32'(lat), 32'd1);
    chk("ld oversize exc", 32'(rspExc), 32'd1);
    chk("ld oversize data", rspData, 32'h0);
    chk("ld oversize reads", 32'(readQ.size()), 32'd0);
    finishRsp;

    // strict instance: spanning and oversize both trap
    sel = 1'b1;
    runLoad(32'h1001, 2'd2, 1'b0, lat);
    chk("strict span latency", 32'(lat), 32'd1);
    chk("strict span exc", 32'(rspExc), 32'd1);
    chk("strict span data", rspData, 32'h0);
    chk("strict span reads", 32'(readQ.size()), 32'd0);
    finishRsp;
    runLoad(32'h1000, 2'd3, 1'b0, lat);
    chk("strict oversize exc", 32'(rspExc), 32'd1);
    finishRsp;
    runLoad(32'h1004, 2'd2, 1'b0, lat);
    chk("strict aligned exc", 32'(rspExc), 32'd0);
    chk("strict aligned data", rspData, 32'h8877_6655);
    finishRsp;
    sel = 1'b0;

    // backpressure with a competing request held on the inputs
    runLoad(32'h1000, 2'd2, 1'b0, lat);
    chk("bp latency", 32'(lat), 32'd2);
    reqAddr = 32'h1004; reqSize = 2'd2; reqUnsigned = 1'b0; reqValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp rsp_valid", 32'(rspValid), 32'd1);
      chk("bp rsp_data", rspData, 32'h4433_2211);
      chk("bp req_ready", 32'(reqReady), 32'd0);
      chk("bp mem_rd_en", 32'(memRdEn), 32'd0);
      tick;
    end
    rspReady = 1'b1;
    tick;
    rspReady = 1'b0;
    readQ.delete();
    chk("bp next req_ready", 32'(reqReady), 32'd1);
    chk("bp next mem_rd_en", 32'(memRdEn), 32'd1);
    chk("bp next mem_addr", memAddr, 32'h1004);
    tick;
    reqValid = 1'b0;
    tick;
    chk("bp next rsp_valid", 32'(rspValid), 32'd1);
    chk("bp next data", rspData, 32'h8877_6655);
    finishRsp;

    // reset while waiting for the second word of a spanning load
    mem[32'h2000] = 32'hDEAD_BEEF;
    reqAddr = 32'h1001; reqSize = 2'd2; reqUnsigned = 1'b0; reqValid = 1'b1;
    #1;
    tick;
    reqValid = 1'b0;
    tick;
    chk("pre-reset rsp_valid", 32'(rspValid), 32'd0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    chk("post-reset rsp_valid", 32'(rspValid), 32'd0);
    chk("post-reset req_ready", 32'(reqReady), 32'd1);
    runLoad(32'h2000, 2'd2, 1'b1, lat);
    chk("post-reset lw latency", 32'(lat), 32'd2);
    chk("post-reset lw data", rspData, 32'hDEAD_BEEF);
    finishRsp;

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
